// File: rtl/ysyx_040066_clint_multi.sv
// Multi-hart core-local interruptor: shared prescaled mtime, per-hart mtimecmp/msip.
// Steals in-window M-stage accesses, forwards the rest; read data returns one cycle later.
module ysyx_040066_clint_multi #(
  parameter int unsigned NHART    = 2,
  parameter logic [63:0] BASE     = 64'h0000_0000_0200_0000,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:0]      addr,
  input  logic [63:0]      data_wr,
  input  logic [7:0]       wr_mask,
  input  logic             MemRd,
  input  logic             MemWr,
  output logic             MemRd_real,
  output logic             MemWr_real,
  output logic             rd_hit,
  output logic [63:0]      data_rd,
  output logic             error,
  output logic [NHART-1:0] mtip,
  output logic [NHART-1:0] msip,
  output logic [63:0]      mtime_o
);

  logic [63:0]      r_mtime;
  logic [31:0]      r_presc;
  logic [63:0]      r_cmp [NHART];
  logic [NHART-1:0] r_msip;
  logic [NHART-1:0] r_mtip;
  logic [63:0]      r_data_rd;
  logic             r_rd_hit;
  logic             r_err;

  logic             w_hit, w_wr, w_acc, w_fault, w_ok_wr, w_tick;
  logic [15:0]      w_off;
  logic             w_is_msip, w_is_cmp, w_is_mtime;
  logic [11:0]      w_msip_idx;
  logic [12:0]      w_cmp_idx;
  logic             w_msip_bit, w_msip_en;
  logic [31:0]      w_presc_nxt;
  logic [63:0]      w_mtime_nxt;
  logic [63:0]      w_cmp_nxt [NHART];
  logic [NHART-1:0] w_msip_nxt;
  logic [NHART-1:0] w_mtip_nxt;
  logic [63:0]      w_rdata;

  function automatic logic [63:0] f_merge(input logic [63:0] old_v,
                                          input logic [63:0] new_v,
                                          input logic [7:0]  m);
    logic [63:0] v;
    v = old_v;
    for (int b = 0; b < 8; b++)
      if (m[b]) v[8*b +: 8] = new_v[8*b +: 8];
    return v;
  endfunction

  assign w_hit      = (addr[63:16] == BASE[63:16]);
  assign MemRd_real = MemRd && !w_hit;
  assign MemWr_real = MemWr && !w_hit;

  // An all-zero byte mask is not treated as a write at all, so it cannot fault.
  assign w_wr  = MemWr && (wr_mask != 8'h00);
  assign w_acc = w_hit && (MemRd || w_wr);

  assign w_off      = addr[15:0];
  assign w_is_msip  = (w_off < 16'h4000);
  assign w_is_cmp   = (w_off >= 16'h4000) && (w_off < 16'hBFF8);
  assign w_is_mtime = (w_off == 16'hBFF8);
  assign w_msip_idx = w_off[13:2];
  assign w_cmp_idx  = w_off[15:3] - 13'h0800;

  // 32-bit msip slot sits in the bus lane chosen by addr[2]; only bit0 is kept.
  assign w_msip_bit = addr[2] ? data_wr[32] : data_wr[0];
  assign w_msip_en  = addr[2] ? wr_mask[4]  : wr_mask[0];

  always_comb begin
    w_fault = 1'b1;
    if (w_is_msip)
      w_fault = (w_off[1:0] != 2'b00) || ({20'b0, w_msip_idx} >= NHART);
    else if (w_is_cmp)
      w_fault = (w_off[2:0] != 3'b000) || ({19'b0, w_cmp_idx} >= NHART);
    else if (w_is_mtime)
      w_fault = 1'b0;
  end

  assign w_ok_wr = w_hit && w_wr && !w_fault;
  assign w_tick  = (r_presc == 32'(TICK_DIV - 1));

  always_comb begin
    w_presc_nxt = w_tick ? 32'd0 : r_presc + 32'd1;
    // A software mtime write wins over a coincident tick.
    if (w_ok_wr && w_is_mtime)
      w_mtime_nxt = f_merge(r_mtime, data_wr, wr_mask);
    else
      w_mtime_nxt = w_tick ? r_mtime + 64'd1 : r_mtime;
    w_cmp_nxt  = r_cmp;
    w_msip_nxt = r_msip;
    for (int unsigned h = 0; h < NHART; h++) begin
      if (w_ok_wr && w_is_cmp && ({19'b0, w_cmp_idx} == h))
        w_cmp_nxt[h] = f_merge(r_cmp[h], data_wr, wr_mask);
      if (w_ok_wr && w_is_msip && w_msip_en && ({20'b0, w_msip_idx} == h))
        w_msip_nxt[h] = w_msip_bit;
    end
    for (int unsigned h = 0; h < NHART; h++)
      w_mtip_nxt[h] = (w_mtime_nxt >= w_cmp_nxt[h]);
  end

  // Reads see pre-write state; an msip read returns the whole doubleword pair.
  always_comb begin
    w_rdata = 64'd0;
    if (w_is_mtime) w_rdata = r_mtime;
    for (int unsigned h = 0; h < NHART; h++) begin
      if (w_is_cmp && ({19'b0, w_cmp_idx} == h))
        w_rdata = r_cmp[h];
      if (w_is_msip && ({21'b0, w_msip_idx[11:1]} == (h >> 1))) begin
        if ((h & 32'd1) != 32'd0) w_rdata[32] = r_msip[h];
        else                      w_rdata[0]  = r_msip[h];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mtime   <= 64'd0;
      r_presc   <= 32'd0;
      for (int h = 0; h < NHART; h++) r_cmp[h] <= '1;
      r_msip    <= '0;
      r_mtip    <= '0;
      r_data_rd <= 64'd0;
      r_rd_hit  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_mtime   <= w_mtime_nxt;
      r_presc   <= w_presc_nxt;
      r_cmp     <= w_cmp_nxt;
      r_msip    <= w_msip_nxt;
      r_mtip    <= w_mtip_nxt;
      r_rd_hit  <= w_hit && MemRd;
      r_err     <= w_acc && w_fault;
      r_data_rd <= (w_hit && MemRd && !w_fault) ? w_rdata : 64'd0;
    end
  end

  assign rd_hit  = r_rd_hit;
  assign data_rd = r_data_rd;
  assign error   = r_err;
  assign mtip    = r_mtip;
  assign msip    = r_msip;
  assign mtime_o = r_mtime;

endmodule
